// File: rtl/dm_load_unit.sv
// Load-side data-memory initiator: issues a word read over req/ack, extracts and extends lb/lbu/lh/lhu/lw results.
// Optional simulation trace of completions and exceptions when DM_LOAD_TRACE_EN is defined.
module dm_load_unit #(
    parameter int unsigned AW      = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [5:0]    opcode,
    input  logic [31:0]   addr,
    input  logic [31:0]   pc,
    output logic          stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [31:0]   ld_data,
    output logic          ld_done,
    output logic          exc,
    output logic [1:0]    exc_code,
    output logic [31:0]   exc_pc
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t          r_state, w_state_nx;
    logic            r_stall, w_stall_nx;
    logic            r_mem_req, w_mem_req_nx;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nx;
    logic [31:0]     r_ld_data, w_ld_data_nx;
    logic            r_ld_done, w_ld_done_nx;
    logic            r_exc, w_exc_nx;
    logic [1:0]      r_exc_code, w_exc_code_nx;
    logic [31:0]     r_exc_pc, w_exc_pc_nx;
    logic [CW-1:0]   r_cnt, w_cnt_nx;
    logic [2:0]      r_op, w_op_nx;        // {unsigned, size[1:0]}
    logic [1:0]      r_b, w_b_nx;
    logic [31:0]     r_pc, w_pc_nx;

    logic            w_op_valid;
    logic            w_misaligned;
    logic [31:0]     w_extracted;

    always_comb begin
        case (opcode)
            6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011: w_op_valid = 1'b1;
            default:                                                 w_op_valid = 1'b0;
        endcase
    end

    always_comb begin
        w_misaligned = 1'b0;
        if (opcode[1:0] == 2'b01 && addr[0])
            w_misaligned = 1'b1;
        else if (opcode[1:0] == 2'b11 && addr[1:0] != 2'b00)
            w_misaligned = 1'b1;
    end

    // Byte/half lane select by the latched low address bits, then sign or zero extension.
    always_comb begin
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (r_b)
            2'd0:    v_byte = mem_rdata[7:0];
            2'd1:    v_byte = mem_rdata[15:8];
            2'd2:    v_byte = mem_rdata[23:16];
            default: v_byte = mem_rdata[31:24];
        endcase
        v_half = r_b[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_op[1:0])
            2'b00:   w_extracted = r_op[2] ? {24'd0, v_byte} : {{24{v_byte[7]}}, v_byte};
            2'b01:   w_extracted = r_op[2] ? {16'd0, v_half} : {{16{v_half[15]}}, v_half};
            default: w_extracted = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_stall    <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_ld_data  <= '0;
            r_ld_done  <= 1'b0;
            r_exc      <= 1'b0;
            r_exc_code <= 2'b00;
            r_exc_pc   <= '0;
            r_cnt      <= '0;
            r_op       <= '0;
            r_b        <= '0;
            r_pc       <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_stall    <= w_stall_nx;
            r_mem_req  <= w_mem_req_nx;
            r_mem_addr <= w_mem_addr_nx;
            r_ld_data  <= w_ld_data_nx;
            r_ld_done  <= w_ld_done_nx;
            r_exc      <= w_exc_nx;
            r_exc_code <= w_exc_code_nx;
            r_exc_pc   <= w_exc_pc_nx;
            r_cnt      <= w_cnt_nx;
            r_op       <= w_op_nx;
            r_b        <= w_b_nx;
            r_pc       <= w_pc_nx;
        end
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        w_state_nx    = r_state;
        w_stall_nx    = r_stall;
        w_mem_req_nx  = r_mem_req;
        w_mem_addr_nx = r_mem_addr;
        w_ld_data_nx  = r_ld_data;
        w_ld_done_nx  = 1'b0;
        w_exc_nx      = 1'b0;
        w_exc_code_nx = r_exc_code;
        w_exc_pc_nx   = r_exc_pc;
        w_cnt_nx      = r_cnt;
        w_op_nx       = r_op;
        w_b_nx        = r_b;
        w_pc_nx       = r_pc;

        case (r_state)
            S_IDLE: begin
                if (ld_valid && w_op_valid) begin
                    w_op_nx    = {opcode[2], opcode[1:0]};
                    w_b_nx     = addr[1:0];
                    w_pc_nx    = pc;
                    w_stall_nx = 1'b1;
                    if (w_misaligned) begin
                        w_state_nx    = S_ERR;
                        w_exc_nx      = 1'b1;
                        w_exc_code_nx = EXC_MISALIGN;
                        w_exc_pc_nx   = pc;
                    end else begin
                        w_state_nx    = S_REQ;
                        w_mem_req_nx  = 1'b1;
                        w_mem_addr_nx = addr[AW+1:2];
                        w_cnt_nx      = '0;
                    end
                end
            end
            S_REQ: begin
                // Ack takes priority over an expiring counter.
                if (mem_ack) begin
                    w_ld_data_nx = w_extracted;
                    w_mem_req_nx = 1'b0;
                    w_ld_done_nx = 1'b1;
                    w_state_nx   = S_DONE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_mem_req_nx  = 1'b0;
                    w_exc_nx      = 1'b1;
                    w_exc_code_nx = EXC_TIMEOUT;
                    w_exc_pc_nx   = r_pc;
                    w_state_nx    = S_ERR;
                end else begin
                    w_cnt_nx = r_cnt + CW'(1);
                end
            end
            S_DONE: begin
                w_stall_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_stall_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign stall    = r_stall;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign ld_data  = r_ld_data;
    assign ld_done  = r_ld_done;
    assign exc      = r_exc;
    assign exc_code = r_exc_code;
    assign exc_pc   = r_exc_pc;

`ifdef DM_LOAD_TRACE_EN
    // The pipeline holds addr until stall falls, so it is still valid in the ld_done cycle.
    always_ff @(posedge clk) begin
        if (r_ld_done)
            $display("%d@%h: %h <= *%h", $time, r_pc, r_ld_data, {addr[31:2], 2'b00});
        if (r_exc)
            $display("%d@%h: load exception code %b", $time, r_exc_pc, r_exc_code);
    end
`else
    logic w_unused;
    assign w_unused = ^{addr[31:AW+2]};
`endif

endmodule

// File: tb/tb_dm_load_unit.sv
// Directed bench for dm_load_unit: extraction, latency, misalignment, slow/absent responder, reset abort.
module tb_dm_load_unit;

    localparam int unsigned AW = 12;

    logic          clk;
    logic          reset;
    logic          ld_valid;
    logic [5:0]    opcode;
    logic [31:0]   addr;
    logic [31:0]   pc;
    logic          stall;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [31:0]   ld_data;
    logic          ld_done;
    logic          exc;
    logic [1:0]    exc_code;
    logic [31:0]   exc_pc;

    dm_load_unit #(.AW(AW), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_valid  (ld_valid),
        .opcode    (opcode),
        .addr      (addr),
        .pc        (pc),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ld_data   (ld_data),
        .ld_done   (ld_done),
        .exc       (exc),
        .exc_code  (exc_code),
        .exc_pc    (exc_pc)
    );

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [0:15];
    int          ack_wait = 1;   // ack in the Nth cycle mem_req is high; 0 = never
    int          req_cnt  = 0;

    logic [1:0]  obs_code;
    logic [31:0] obs_epc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural responder, updated a little after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (mem_req) req_cnt = req_cnt + 1;
        else         req_cnt = 0;
        mem_ack   = mem_req && (ack_wait != 0) && (req_cnt == ack_wait);
        mem_rdata = mem_ack ? mem[mem_addr[3:0]] : 32'hDEAD_BEEF;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one load at cycle 0 and follow it until stall falls (bounded).
    task automatic run_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] p,
                            input int wait_n, output int done_cyc, output int exc_cyc,
                            output int req_cyc, output logic addr_stable);
        logic finished;
        opcode   = op;
        addr     = a;
        pc       = p;
        ack_wait = wait_n;
        ld_valid = 1'b1;
        done_cyc = -1;
        exc_cyc  = -1;
        req_cyc  = 0;
        addr_stable = 1'b1;
        finished = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                req_cyc++;
                if (mem_addr != a[AW+1:2]) addr_stable = 1'b0;
            end
            if (ld_done) done_cyc = c;
            if (exc) begin
                exc_cyc  = c;
                obs_code = exc_code;
                obs_epc  = exc_pc;
            end
            if (!stall) begin
                finished = 1'b1;
                break;
            end
        end
        ld_valid = 1'b0;
        if (!finished) check("stall_release_bound", 32'd0, 32'd1);
    endtask

    int   d, e, r;
    logic st;
    logic [31:0] prev;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * 32'(i);
        mem[3] = 32'h8844_22F1;
        mem[5] = 32'hCAFE_F00D;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        reset     = 1'b1;
        ld_valid  = 1'b0;
        opcode    = 6'd0;
        addr      = 32'd0;
        pc        = 32'd0;
        obs_code  = 2'b00;
        obs_epc   = 32'd0;

        #12;
        check("rst_stall",    32'(stall),    32'd0);
        check("rst_mem_req",  32'(mem_req),  32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_ld_data",  ld_data,       32'd0);
        check("rst_ld_done",  32'(ld_done),  32'd0);
        check("rst_exc",      32'(exc),      32'd0);
        check("rst_exc_code", 32'(exc_code), 32'd0);
        check("rst_exc_pc",   exc_pc,        32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero-wait byte/word loads from word 3.
        run_load(OP_LB, 32'h0000_000C, 32'h0000_1000, 1, d, e, r, st);
        check("lb_data", ld_data, 32'hFFFF_FFF1);
        check("lb_done_cyc", 32'(d), 32'd2);
        check("lb_no_exc", 32'(e), 32'hFFFF_FFFF);
        check("lb_req_cyc", 32'(r), 32'd1);
        @(posedge clk); #1;

        run_load(OP_LBU, 32'h0000_000C, 32'h0000_1004, 1, d, e, r, st);
        check("lbu_data", ld_data, 32'h0000_00F1);
        check("lbu_done_cyc", 32'(d), 32'd2);
        @(posedge clk); #1;

        run_load(OP_LW, 32'h0000_000C, 32'h0000_1008, 1, d, e, r, st);
        check("lw_data", ld_data, 32'h8844_22F1);
        check("lw_done_cyc", 32'(d), 32'd2);
        @(posedge clk); #1;

        // Upper half and top byte lanes.
        run_load(OP_LH, 32'h0000_000E, 32'h0000_100C, 1, d, e, r, st);
        check("lh_data", ld_data, 32'hFFFF_8844);
        @(posedge clk); #1;
        run_load(OP_LHU, 32'h0000_000E, 32'h0000_1010, 1, d, e, r, st);
        check("lhu_data", ld_data, 32'h0000_8844);
        @(posedge clk); #1;
        run_load(OP_LB, 32'h0000_000F, 32'h0000_1014, 1, d, e, r, st);
        check("lb_b3_data", ld_data, 32'hFFFF_FF88);
        @(posedge clk); #1;

        // Misaligned loads: no handshake, exception in cycle 1, ld_data untouched.
        prev = ld_data;
        run_load(OP_LW, 32'h0000_0006, 32'h0000_2000, 1, d, e, r, st);
        check("mis_lw_exc_cyc", 32'(e), 32'd1);
        check("mis_lw_code", 32'(obs_code), 32'd1);
        check("mis_lw_pc", obs_epc, 32'h0000_2000);
        check("mis_lw_req", 32'(r), 32'd0);
        check("mis_lw_done", 32'(d), 32'hFFFF_FFFF);
        check("mis_lw_data", ld_data, prev);
        @(posedge clk); #1;
        run_load(OP_LH, 32'h0000_0003, 32'h0000_2004, 1, d, e, r, st);
        check("mis_lh_exc_cyc", 32'(e), 32'd1);
        check("mis_lh_code", 32'(obs_code), 32'd1);
        check("mis_lh_pc", obs_epc, 32'h0000_2004);
        check("mis_lh_req", 32'(r), 32'd0);
        @(posedge clk); #1;

        // Slow responder: ack in the fifth request cycle.
        run_load(OP_LW, 32'h0000_0014, 32'h0000_3000, 5, d, e, r, st);
        check("slow_req_cyc", 32'(r), 32'd5);
        check("slow_addr_stable", 32'(st), 32'd1);
        check("slow_done_cyc", 32'(d), 32'd6);
        check("slow_data", ld_data, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Absent responder: timeout after 16 request cycles.
        prev = ld_data;
        run_load(OP_LW, 32'h0000_0010, 32'h0000_3004, 0, d, e, r, st);
        check("to_req_cyc", 32'(r), 32'd16);
        check("to_exc_cyc", 32'(e), 32'd17);
        check("to_code", 32'(obs_code), 32'd2);
        check("to_pc", obs_epc, 32'h0000_3004);
        check("to_done", 32'(d), 32'hFFFF_FFFF);
        check("to_data", ld_data, prev);
        @(posedge clk); #1;

        // Reset in REQ aborts the load with no completion or exception.
        opcode = OP_LW; addr = 32'h0000_000C; pc = 32'h0000_4000; ack_wait = 0;
        ld_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_pre_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        ld_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        d = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (ld_done || exc || mem_req) d++;
        end
        check("abort_quiet", 32'(d), 32'd0);
        run_load(OP_LW, 32'h0000_000C, 32'h0000_4004, 1, d, e, r, st);
        check("post_rst_data", ld_data, 32'h8844_22F1);
        check("post_rst_done_cyc", 32'(d), 32'd2);
        @(posedge clk); #1;

        // Invalid opcode is ignored entirely.
        prev = ld_data;
        run_load(OP_SW, 32'h0000_000C, 32'h0000_5000, 1, d, e, r, st);
        check("inv_req", 32'(r), 32'd0);
        check("inv_done", 32'(d), 32'hFFFF_FFFF);
        check("inv_exc", 32'(e), 32'hFFFF_FFFF);
        check("inv_stall", 32'(stall), 32'd0);
        check("inv_data", ld_data, prev);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
